// File: rtl/video_rd_pkg.sv
// Shared constants for the Z80 video register read side.
package video_rd_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] RD_VCONF   = 5'h00;
    localparam logic [ADDR_W-1:0] RD_VPAGE   = 5'h01;
    localparam logic [ADDR_W-1:0] RD_BORDER  = 5'h02;
    localparam logic [ADDR_W-1:0] RD_PALSEL  = 5'h03;
    localparam logic [ADDR_W-1:0] RD_VLINE_L = 5'h04;
    localparam logic [ADDR_W-1:0] RD_VLINE_H = 5'h05;
    localparam logic [ADDR_W-1:0] RD_HCNT    = 5'h06;
    localparam logic [ADDR_W-1:0] RD_FRAME   = 5'h07;
    localparam logic [ADDR_W-1:0] RD_INTSTAT = 5'h08;
    localparam logic [ADDR_W-1:0] RD_VINT_L  = 5'h09;
    localparam logic [ADDR_W-1:0] RD_VINT_H  = 5'h0A;

    localparam int unsigned INT_FRAME = 0;
    localparam int unsigned INT_LINE  = 1;
    localparam int unsigned INT_OVF   = 2;

    localparam logic [DATA_W-1:0] RD_DEFAULT = 8'hFF;

endpackage

// File: rtl/video_int_flags.sv
// Frame/line interrupt pending flags with overflow, read-to-clear, and the registered IRQ.
module video_int_flags
    import video_rd_pkg::*;
(
    input  logic       clk,
    input  logic       res_n,
    input  logic       int_start,
    input  logic       hint_start,
    input  logic       clr,
    input  logic [1:0] int_mask,
    output logic       frame_pend,
    output logic       line_pend,
    output logic       ovf,
    output logic       irq
);

    // A new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            frame_pend <= 1'b0;
            line_pend  <= 1'b0;
            ovf        <= 1'b0;
            irq        <= 1'b0;
        end else begin
            frame_pend <= int_start  | (frame_pend & ~clr);
            line_pend  <= hint_start | (line_pend  & ~clr);
            ovf        <= (int_start & frame_pend) | (hint_start & line_pend) | (ovf & ~clr);
            irq        <= (frame_pend & int_mask[INT_FRAME]) | (line_pend & int_mask[INT_LINE]);
        end
    end

endmodule

// File: rtl/video_ports_rd.sv
// Z80 read side of the video register file: config readback, raster snapshot,
// frame counter and read-to-clear interrupt status.
module video_ports_rd
    import video_rd_pkg::*;
(
    input  logic        clk,
    input  logic        res_n,
    input  logic        rd_stb,
    input  logic [4:0]  rd_addr,
    input  logic        int_start,
    input  logic        hint_start,
    input  logic [1:0]  int_mask,
    input  logic [8:0]  vcnt,
    input  logic [7:0]  hcnt,
    input  logic [7:0]  vconf,
    input  logic [7:0]  vpage,
    input  logic [7:0]  border,
    input  logic [7:0]  palsel,
    input  logic [8:0]  vint_beg,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        irq
);

    logic       snap_v8;
    logic [7:0] frame_cnt;
    logic       frame_pend;
    logic       line_pend;
    logic       ovf;
    logic [7:0] rd_mux_c;
    logic [7:0] intstat_c;
    logic       stat_clr_c;

    always_comb begin
        intstat_c          = 8'h00;
        intstat_c[INT_FRAME] = frame_pend;
        intstat_c[INT_LINE]  = line_pend;
        intstat_c[INT_OVF]   = ovf;
    end

    assign stat_clr_c = rd_stb && (rd_addr == RD_INTSTAT);

    always_comb begin
        rd_mux_c = RD_DEFAULT;
        case (rd_addr)
            RD_VCONF:   rd_mux_c = vconf;
            RD_VPAGE:   rd_mux_c = vpage;
            RD_BORDER:  rd_mux_c = border;
            RD_PALSEL:  rd_mux_c = palsel;
            RD_VLINE_L: rd_mux_c = vcnt[7:0];
            RD_VLINE_H: rd_mux_c = {7'b0, snap_v8};
            RD_HCNT:    rd_mux_c = hcnt;
            RD_FRAME:   rd_mux_c = frame_cnt;
            RD_INTSTAT: rd_mux_c = intstat_c;
            RD_VINT_L:  rd_mux_c = vint_beg[7:0];
            RD_VINT_H:  rd_mux_c = {7'b0, vint_beg[8]};
            default:    rd_mux_c = RD_DEFAULT;
        endcase
    end

    // Read data register; the high line bit is frozen when the low byte is read.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            rd_data   <= RD_DEFAULT;
            rd_valid  <= 1'b0;
            snap_v8   <= 1'b0;
            frame_cnt <= 8'h00;
        end else begin
            rd_valid <= rd_stb;
            if (rd_stb) begin
                rd_data <= rd_mux_c;
                if (rd_addr == RD_VLINE_L) begin
                    snap_v8 <= vcnt[8];
                end
            end
            if (int_start) begin
                frame_cnt <= frame_cnt + 8'(1);
            end
        end
    end

    video_int_flags u_int_flags (
        .clk        (clk),
        .res_n      (res_n),
        .int_start  (int_start),
        .hint_start (hint_start),
        .clr        (stat_clr_c),
        .int_mask   (int_mask),
        .frame_pend (frame_pend),
        .line_pend  (line_pend),
        .ovf        (ovf),
        .irq        (irq)
    );

endmodule

// File: tb/tb_video_ports_rd.sv
// Directed bench for video_ports_rd: register table plus multi-cycle corner sequences.
module tb_video_ports_rd;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       rd_stb = 1'b0;
    logic [4:0] rd_addr = 5'h00;
    logic       int_start = 1'b0;
    logic       hint_start = 1'b0;
    logic [1:0] int_mask = 2'b00;
    logic [8:0] vcnt = 9'h000;
    logic [7:0] hcnt = 8'h9A;
    logic [7:0] vconf = 8'h3C;
    logic [7:0] vpage = 8'h81;
    logic [7:0] border = 8'h07;
    logic [7:0] palsel = 8'hF0;
    logic [8:0] vint_beg = 9'h000;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] addr;
        logic [8:0] vcnt;
        logic [8:0] vint;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    video_ports_rd dut (
        .clk        (clk),
        .res_n      (res_n),
        .rd_stb     (rd_stb),
        .rd_addr    (rd_addr),
        .int_start  (int_start),
        .hint_start (hint_start),
        .int_mask   (int_mask),
        .vcnt       (vcnt),
        .hcnt       (hcnt),
        .vconf      (vconf),
        .vpage      (vpage),
        .border     (border),
        .palsel     (palsel),
        .vint_beg   (vint_beg),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Strobe one read (optionally with events in the same cycle) and check the result at N+1.
    task automatic rd(input string nm, input logic [4:0] a, input logic ef, input logic eh,
                      input logic [7:0] exp);
        @(negedge clk);
        rd_stb = 1'b1;
        rd_addr = a;
        int_start = ef;
        hint_start = eh;
        @(negedge clk);
        rd_stb = 1'b0;
        int_start = 1'b0;
        hint_start = 1'b0;
        chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
        chk({nm, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        int_start = 1'b1;
        @(negedge clk);
        int_start = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'h00, 9'h000, 9'h000, 8'h3C};
        vecs[1]  = '{5'h01, 9'h000, 9'h000, 8'h81};
        vecs[2]  = '{5'h02, 9'h000, 9'h000, 8'h07};
        vecs[3]  = '{5'h03, 9'h000, 9'h000, 8'hF0};
        vecs[4]  = '{5'h06, 9'h000, 9'h000, 8'h9A};
        vecs[5]  = '{5'h09, 9'h000, 9'h1A5, 8'hA5};
        vecs[6]  = '{5'h0A, 9'h000, 9'h1A5, 8'h01};
        vecs[7]  = '{5'h0A, 9'h000, 9'h0A5, 8'h00};
        vecs[8]  = '{5'h04, 9'h123, 9'h000, 8'h23};
        vecs[9]  = '{5'h05, 9'h000, 9'h000, 8'h01};
        vecs[10] = '{5'h0B, 9'h000, 9'h000, 8'hFF};
        vecs[11] = '{5'h1F, 9'h000, 9'h000, 8'hFF};

        // Reset with strobes and events attempted
        res_n = 1'b0;
        rd_stb = 1'b1;
        rd_addr = 5'h00;
        int_start = 1'b1;
        hint_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(rd_data), 32'hFF);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_stb = 1'b0;
        int_start = 1'b0;
        hint_start = 1'b0;
        res_n = 1'b1;
        rd("rst_frame", 5'h07, 1'b0, 1'b0, 8'h00);
        rd("rst_intstat", 5'h08, 1'b0, 1'b0, 8'h00);

        // Register table
        for (int i = 0; i < 12; i++) begin
            vcnt = vecs[i].vcnt;
            vint_beg = vecs[i].vint;
            rd($sformatf("vec%0d", i), vecs[i].addr, 1'b0, 1'b0, vecs[i].exp);
            @(negedge clk);
            chk($sformatf("vec%0d_drop", i), 32'(rd_valid), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(rd_data), 32'(vecs[i].exp));
        end

        // Frame counter: 255 then 256 events
        @(negedge clk);
        int_start = 1'b1;
        repeat (255) @(negedge clk);
        int_start = 1'b0;
        rd("frame_255", 5'h07, 1'b0, 1'b0, 8'hFF);
        pulse_frame();
        rd("frame_256", 5'h07, 1'b0, 1'b0, 8'h00);
        rd("wrap_intstat", 5'h08, 1'b0, 1'b0, 8'h05);

        // Frame read coincident with int_start returns pre-increment value
        rd("frame_same", 5'h07, 1'b1, 1'b0, 8'h00);
        rd("frame_after", 5'h07, 1'b0, 1'b0, 8'h01);
        rd("clr_pre_race", 5'h08, 1'b0, 1'b0, 8'h01);

        // Clear race: new line event in the clearing cycle survives
        pulse_frame();
        rd("race_first", 5'h08, 1'b0, 1'b1, 8'h01);
        rd("race_second", 5'h08, 1'b0, 1'b0, 8'h02);

        // Overflow with frame IRQ masked off
        int_mask = 2'b10;
        pulse_frame();
        pulse_frame();
        repeat (2) @(negedge clk);
        chk("mask_irq_low", 32'(irq), 32'd0);
        rd("ovf_intstat", 5'h08, 1'b0, 1'b0, 8'h05);
        chk("mask_irq_low2", 32'(irq), 32'd0);

        // Frame IRQ enabled: irq two cycles after event, drops two cycles after clear
        int_mask = 2'b01;
        @(negedge clk);
        int_start = 1'b1;
        @(negedge clk);
        int_start = 1'b0;
        chk("irq_n1", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_n2", 32'(irq), 32'd1);
        rd("irq_clr", 5'h08, 1'b0, 1'b0, 8'h01);
        chk("irq_clr_n1", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_clr_n2", 32'(irq), 32'd0);
        int_mask = 2'b00;

        // Back-to-back strobes, mapped then unmapped
        border = 8'hA5;
        @(negedge clk);
        rd_stb = 1'b1;
        rd_addr = 5'h02;
        @(negedge clk);
        chk("b2b_v1", 32'(rd_valid), 32'd1);
        chk("b2b_d1", 32'(rd_data), 32'hA5);
        rd_addr = 5'h15;
        @(negedge clk);
        rd_stb = 1'b0;
        chk("b2b_v2", 32'(rd_valid), 32'd1);
        chk("b2b_d2", 32'(rd_data), 32'hFF);
        @(negedge clk);
        chk("b2b_v3", 32'(rd_valid), 32'd0);

        // Snapshot across a vcnt wrap
        vcnt = 9'h1FF;
        rd("snap_l", 5'h04, 1'b0, 1'b0, 8'hFF);
        vcnt = 9'h000;
        repeat (3) @(negedge clk);
        rd("snap_h", 5'h05, 1'b0, 1'b0, 8'h01);
        vcnt = 9'h0FF;
        rd("snap_l2", 5'h04, 1'b0, 1'b0, 8'hFF);
        vcnt = 9'h100;
        rd("snap_h2", 5'h05, 1'b0, 1'b0, 8'h00);

        // Reset arriving on the edge that would capture a read
        pulse_frame();
        @(negedge clk);
        rd_stb = 1'b1;
        rd_addr = 5'h02;
        res_n = 1'b0;
        @(negedge clk);
        rd_stb = 1'b0;
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_data", 32'(rd_data), 32'hFF);
        res_n = 1'b1;
        rd("midrst_frame", 5'h07, 1'b0, 1'b0, 8'h00);
        rd("midrst_vline_h", 5'h05, 1'b0, 1'b0, 8'h00);
        rd("midrst_intstat", 5'h08, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
